fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//   Shares the async FIFO write port among NREQ requesters in the write-clock domain.
//   Grants the port to one requester per burst, using round-robin order.
//   Drives wq/write_data into the FIFO and stalls on wfull.
//   A burst ends on req_last or when MAX_BURST beats have been written.
// PARAMETERS
//   DSIZE      8   data width; matches the FIFO DSIZE
//   NREQ       4   number of requesters; must be >= 2
//   MAX_BURST  8   maximum beats per grant; must be >= 1
//   GW         $clog2(NREQ)   localparam; width of grant_id
// PORTS
//   wclk         in   1           write-domain clock; all logic is on its rising edge
//   wrst_n       in   1           reset: asynchronous assert, active-low
//   req_valid    in   NREQ        per-requester beat valid
//   req_data     in   NREQ*DSIZE  requester i data is on bits [i*DSIZE +: DSIZE]
//   req_last     in   NREQ        per-requester last beat of a packet; qualified by valid
//   req_ready    out  NREQ        per-requester beat accepted this cycle
//   wq           out  1           FIFO write enable
//   write_data   out  DSIZE       FIFO write data
//   wfull        in   1           FIFO full flag
//   grant_valid  out  1           high while a burst is granted
//   grant_id     out  GW          index of the granted requester
//   burst_trunc  out  1           1-cycle pulse: burst ended at MAX_BURST without last
// BEHAVIOUR
//   Reset values
//   - Registers: state=IDLE, grant_id=0, grant_valid=0, beat_cnt=0, burst_trunc=0, rr_ptr=NREQ-1.
//   - Outputs while reset is asserted: wq=0, req_ready=0, write_data=0.
//   State IDLE
//   - If any req_valid is high, select the first set index scanning rr_ptr+1, rr_ptr+2, ... mod NREQ.
//   - Register that index as grant_id, set grant_valid=1, beat_cnt=0, go to BURST.
//   - Latency: one arbitration cycle from req_valid to grant. No beats transfer in IDLE.
//   - If no req_valid is high, stay in IDLE.
//   State BURST (g = grant_id)
//   - req_ready[g] = !wfull. req_ready is 0 for all other requesters.
//   - xfer = req_valid[g] & !wfull (combinational).
//   - wq = xfer. write_data = req_data[g]; it is 0 when state is not BURST.
//   - On xfer: beat_cnt increments.
//   - End condition: xfer & (req_last[g] | beat_cnt == MAX_BURST-1).
//   - On end: rr_ptr<=g, grant_valid<=0, state<=IDLE.
//   - Also on end: burst_trunc<=1 for one cycle if req_last[g]=0.
//   - req_valid[g] low mid-burst: the grant is held, wq=0, no other requester is served.
//     Requesters must not abandon a packet.
//   - wfull high: ready=0, wq=0, beat_cnt frozen. Resume with no loss or duplication.
//   - wfull and req_last in the same cycle: no transfer and no end; the last beat waits.
//   - beat_cnt width is $clog2(MAX_BURST)+1 and never exceeds MAX_BURST-1.
//   - When MAX_BURST=1, every beat ends the burst.
//   Fairness and reset
//   - After a burst from g, every other waiting requester is granted before g again.
//   - Reset mid-burst: return to IDLE immediately (asynchronous).
//     Any beat not yet clocked is not written. The next grant goes to requester 0.
//   - Registers are fully synchronous to wclk. No CDC logic here; the FIFO handles the crossing.
// TESTING
//   1. Only req0 valid, 3 beats 0xA1,0xA2,0xA3, last on beat 3, wfull=0
//      -> grant_id=0 one cycle after valid; wq high 3 consecutive cycles with data A1,A2,A3; then IDLE.
//   2. req0,req1,req2 always valid, last on every beat
//      -> grant order 0,1,2,0,1; one wq beat per grant; one IDLE cycle between grants.
//   3. MAX_BURST=4; req1 sends 6 beats, no last; req3 pending
//      -> 4 beats from req1; burst_trunc pulse; req3 granted next; req1 later resumes with beats 5-6.
//   4. wfull high for 5 cycles after beat 2 of a 4-beat burst
//      -> wq=0 and req_ready=0 for 5 cycles; beats 3-4 follow; the FIFO receives exactly 4 beats in order.
//   5. wrst_n low mid-burst on req2
//      -> wq, grant_valid and req_ready drop at once; after release with req0 and req2 valid, req0 is granted.
//   6. req1 drops valid for 3 cycles mid-burst while req0 is valid
//      -> grant stays on req1; no req0 beats; burst completes on req1 last.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one async FIFO write port among NREQ
// requesters, one burst per grant, bounded by req_last or MAX_BURST beats.
module fifo_wr_arbiter #(
  parameter int DSIZE     = 8,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 8,
  localparam int GW       = $clog2(NREQ)
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  output logic                  wq,
  output logic [DSIZE-1:0]      write_data,
  input  logic                  wfull,
  output logic                  grant_valid,
  output logic [GW-1:0]         grant_id,
  output logic                  burst_trunc
);

  localparam int CW = $clog2(MAX_BURST) + 1;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t          state;
  logic [GW-1:0]   rr_ptr;
  logic [GW-1:0]   pick;
  logic            any_req;
  logic [CW-1:0]   beat_cnt;
  logic            bursting;
  logic            xfer;
  logic            last_g;
  logic            at_max;

  // Walk from the farthest slot down so the nearest one after rr_ptr wins.
  always_comb begin
    pick    = '0;
    any_req = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NREQ;
      if (req_valid[idx]) begin
        pick    = GW'(idx);
        any_req = 1'b1;
      end
    end
  end

  assign bursting = (state == BURST);
  assign xfer     = bursting & req_valid[grant_id] & ~wfull;
  assign last_g   = req_last[grant_id];
  assign at_max   = (beat_cnt == CW'(MAX_BURST - 1));
  assign wq       = xfer;

  always_comb begin
    write_data = '0;
    if (bursting)
      write_data = req_data[grant_id*DSIZE +: DSIZE];
  end

  always_comb begin
    req_ready = '0;
    if (bursting && !wfull)
      req_ready[grant_id] = 1'b1;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state       <= IDLE;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      beat_cnt    <= '0;
      burst_trunc <= 1'b0;
      rr_ptr      <= GW'(NREQ - 1);
    end else begin
      burst_trunc <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            grant_id    <= pick;
            grant_valid <= 1'b1;
            beat_cnt    <= '0;
            state       <= BURST;
          end
        end
        BURST: begin
          if (xfer) begin
            if (last_g || at_max) begin
              rr_ptr      <= grant_id;
              grant_valid <= 1'b0;
              beat_cnt    <= '0;
              burst_trunc <= ~last_g;
              state       <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: vector table, directed corner sequences and
// random traffic checked against a burst-level round-robin model.
module tb_fifo_wr_arbiter;

  localparam int DW   = 8;
  localparam int N    = 4;
  localparam int MAXB = 4;

  logic          wclk = 1'b0;
  logic          wrst_n = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]  req_last = '0;
  logic [N-1:0]  req_ready;
  logic          wq;
  logic [DW-1:0] write_data;
  logic          wfull = 1'b0;
  logic          grant_valid;
  logic [1:0]    grant_id;
  logic          burst_trunc;

  fifo_wr_arbiter #(
    .DSIZE(DW),
    .NREQ(N),
    .MAX_BURST(MAXB)
  ) dut (
    .wclk(wclk),
    .wrst_n(wrst_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .wq(wq),
    .write_data(write_data),
    .wfull(wfull),
    .grant_valid(grant_valid),
    .grant_id(grant_id),
    .burst_trunc(burst_trunc)
  );

  always #5 wclk = ~wclk;

  int checks = 0;
  int failures = 0;

  // Model: owner of the port (-1 when free), last served, beats in burst
  int m_owner;
  int m_last;
  int m_cnt;
  int m_xfer_id;
  bit m_trunc;
  int m_nx;

  logic [7:0] got_q[$];

  typedef struct {
    bit          rst;
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    logic        f;
    logic        gv;
    logic [1:0]  gid;
    logic        wq;
    logic [3:0]  rdy;
    logic [7:0]  wd;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner   = -1;
    m_last    = N - 1;
    m_cnt     = 0;
    m_trunc   = 1'b0;
    m_xfer_id = -1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    wfull     = 1'b0;
    wrst_n    = 1'b0;
    repeat (2) @(posedge wclk);
    #3 wrst_n = 1'b1;
    @(posedge wclk);
    #1;
    model_reset();
    got_q.delete();
  endtask

  task automatic add(input bit rst, input logic [3:0] v, input logic [3:0] l,
                     input logic [31:0] d, input logic gv,
                     input logic [1:0] gid, input logic w,
                     input logic [3:0] rdy, input logic [7:0] wd);
    vec_t t;
    t.rst = rst; t.v = v; t.l = l; t.d = d; t.f = 1'b0;
    t.gv = gv; t.gid = gid; t.wq = w; t.rdy = rdy; t.wd = wd;
    tbl.push_back(t);
  endtask

  // One cycle: drive, check against the model, clock, advance the model.
  task automatic step(input logic [3:0] sv, input logic [3:0] sl,
                      input logic [31:0] sd, input logic sf);
    bit         e_gv;
    bit         e_wq;
    logic [3:0] e_rdy;
    logic [7:0] e_wd;
    bit         found;
    req_valid = sv;
    req_last  = sl;
    req_data  = sd;
    wfull     = sf;
    #3;
    e_gv  = (m_owner >= 0);
    e_wq  = 1'b0;
    e_rdy = '0;
    e_wd  = '0;
    if (e_gv) begin
      e_wq = sv[m_owner] && !sf;
      e_wd = sd[m_owner*8 +: 8];
      if (!sf) e_rdy[m_owner] = 1'b1;
    end
    chk("grant_valid", grant_valid, e_gv);
    chk("wq", wq, e_wq);
    chk("req_ready", req_ready, e_rdy);
    chk("write_data", write_data, e_wd);
    chk("burst_trunc", burst_trunc, m_trunc);
    if (e_gv) chk("grant_id", grant_id, m_owner);
    if (wq === 1'b1) got_q.push_back(write_data);
    @(posedge wclk);
    m_xfer_id = e_wq ? m_owner : -1;
    m_trunc   = 1'b0;
    if (!e_gv) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        if (!found && sv[(m_last + k) % N]) begin
          found   = 1'b1;
          m_owner = (m_last + k) % N;
          m_cnt   = 0;
        end
      end
    end else if (e_wq) begin
      m_nx++;
      m_cnt++;
      if (sl[m_owner] || m_cnt == MAXB) begin
        m_trunc = !sl[m_owner];
        m_last  = m_owner;
        m_owner = -1;
      end
    end
    #1;
  endtask

  logic [3:0]  v, l;
  logic [31:0] d;
  logic        f;
  int          b1, idx, fc, trc;
  bit          done3;
  int          rem[N];
  logic [7:0]  cur[N];
  logic [7:0]  exp3[7];
  logic [7:0]  exp4[4];
  logic [7:0]  exp6[3];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    m_nx = 0;

    // Single requester, 3-beat packet; then three requesters, 1-beat packets
    add(1, 4'h1, 4'h0, 32'hA1, 0, 0, 0, 4'h0, 8'h00);
    add(0, 4'h1, 4'h0, 32'hA1, 1, 0, 1, 4'h1, 8'hA1);
    add(0, 4'h1, 4'h0, 32'hA2, 1, 0, 1, 4'h1, 8'hA2);
    add(0, 4'h1, 4'h1, 32'hA3, 1, 0, 1, 4'h1, 8'hA3);
    add(0, 4'h0, 4'h0, 32'h00, 0, 0, 0, 4'h0, 8'h00);
    add(1, 4'h7, 4'h7, 32'hC2C1C0, 0, 0, 0, 4'h0, 8'h00);
    add(0, 4'h7, 4'h7, 32'hC2C1C0, 1, 0, 1, 4'h1, 8'hC0);
    add(0, 4'h7, 4'h7, 32'hC2C1C0, 0, 0, 0, 4'h0, 8'h00);
    add(0, 4'h7, 4'h7, 32'hC2C1C0, 1, 1, 1, 4'h2, 8'hC1);
    add(0, 4'h7, 4'h7, 32'hC2C1C0, 0, 0, 0, 4'h0, 8'h00);
    add(0, 4'h7, 4'h7, 32'hC2C1C0, 1, 2, 1, 4'h4, 8'hC2);
    add(0, 4'h7, 4'h7, 32'hC2C1C0, 0, 0, 0, 4'h0, 8'h00);
    add(0, 4'h7, 4'h7, 32'hC2C1C0, 1, 0, 1, 4'h1, 8'hC0);
    add(0, 4'h7, 4'h7, 32'hC2C1C0, 0, 0, 0, 4'h0, 8'h00);
    add(0, 4'h7, 4'h7, 32'hC2C1C0, 1, 1, 1, 4'h2, 8'hC1);

    do_reset();
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_burst_trunc", burst_trunc, 0);
    chk("rst_wq", wq, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_write_data", write_data, 0);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      req_valid = tbl[i].v;
      req_last  = tbl[i].l;
      req_data  = tbl[i].d;
      wfull     = tbl[i].f;
      #3;
      chk($sformatf("tbl%0d_gv", i), grant_valid, tbl[i].gv);
      chk($sformatf("tbl%0d_wq", i), wq, tbl[i].wq);
      chk($sformatf("tbl%0d_rdy", i), req_ready, tbl[i].rdy);
      chk($sformatf("tbl%0d_wd", i), write_data, tbl[i].wd);
      if (tbl[i].gv) chk($sformatf("tbl%0d_gid", i), grant_id, tbl[i].gid);
      @(posedge wclk);
      #1;
    end

    // Truncated burst on req1, req3 served in between, req1 resumes
    do_reset();
    b1 = 0; done3 = 0; trc = 0;
    for (int c = 0; c < 14; c++) begin
      v = {done3 ? 1'b0 : 1'b1, 1'b0, (b1 < 6) ? 1'b1 : 1'b0, 1'b0};
      l = {1'b1, 1'b0, (b1 == 5) ? 1'b1 : 1'b0, 1'b0};
      d = {8'h3F, 8'h00, 8'(8'h50 + b1), 8'h00};
      step(v, l, d, 1'b0);
      if (m_trunc) trc++;
      if (burst_trunc === 1'b1) trc += 100;
      if (m_xfer_id == 1) b1++;
      if (m_xfer_id == 3) done3 = 1'b1;
    end
    chk("t3_trunc_pulse", trc, 101);
    chk("t3_beats", got_q.size(), 7);
    exp3 = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h3F, 8'h54, 8'h55};
    foreach (exp3[i]) chk($sformatf("t3_beat%0d", i), got_q[i], exp3[i]);

    // wfull stall for 5 cycles after beat 2 of a 4-beat burst
    do_reset();
    idx = 0; fc = 0;
    for (int c = 0; c < 16; c++) begin
      f = (idx == 2 && fc < 5);
      step({3'b0, (idx < 4) ? 1'b1 : 1'b0}, {3'b0, (idx == 3) ? 1'b1 : 1'b0},
           {24'h0, 8'(8'hB1 + idx)}, f);
      if (f) fc++;
      if (m_xfer_id == 0) idx++;
    end
    chk("t4_beats", got_q.size(), 4);
    exp4 = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
    foreach (exp4[i]) chk($sformatf("t4_beat%0d", i), got_q[i], exp4[i]);

    // Reset mid-burst on req2, then req0 must win
    do_reset();
    step(4'b0100, 4'h0, 32'h00C70000, 1'b0);
    step(4'b0101, 4'h0, 32'h00C700E0, 1'b0);
    wrst_n = 1'b0;
    #1;
    chk("t5_wq", wq, 0);
    chk("t5_gv", grant_valid, 0);
    chk("t5_rdy", req_ready, 0);
    chk("t5_wd", write_data, 0);
    @(posedge wclk);
    #1 wrst_n = 1'b1;
    model_reset();
    got_q.delete();
    step(4'b0101, 4'h0, 32'h00C700E0, 1'b0);
    chk("t5_gid", grant_id, 0);
    step(4'b0101, 4'h1, 32'h00C700E0, 1'b0);
    chk("t5_first_beat", got_q[0], 8'hE0);

    // req1 drops valid mid-burst while req0 waits
    do_reset();
    step(4'b0010, 4'h0, 32'h0000D0E0, 1'b0);
    step(4'b0011, 4'h0, 32'h0000D0E0, 1'b0);
    repeat (3) step(4'b0001, 4'h0, 32'h0000D1E0, 1'b0);
    step(4'b0011, 4'b0010, 32'h0000D1E0, 1'b0);
    step(4'b0001, 4'b0001, 32'h0000D1E0, 1'b0);
    step(4'b0001, 4'b0001, 32'h0000D1E0, 1'b0);
    chk("t6_beats", got_q.size(), 3);
    exp6 = '{8'hD0, 8'hD1, 8'hE0};
    foreach (exp6[i]) chk($sformatf("t6_beat%0d", i), got_q[i], exp6[i]);

    // Random traffic against the model
    do_reset();
    m_nx = 0;
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      cur[i] = 8'($urandom);
    end
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0) rem[i] = $urandom_range(1, 6);
        v[i] = ($urandom % 4) != 0;
        l[i] = (rem[i] == 1);
        d[i*8 +: 8] = cur[i];
      end
      f = ($urandom % 4) == 0;
      step(v, l, d, f);
      if (m_xfer_id >= 0) begin
        rem[m_xfer_id]--;
        cur[m_xfer_id] = 8'($urandom);
      end
    end
    chk("rand_beat_count", got_q.size(), m_nx);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
